// File: rtl/ans_pkg.sv
// Shared defaults, width helper and handshake state encoding for the ANS table loader.
package ans_pkg;

    localparam int DEF_SYM_WIDTH  = 4;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_PREC_WIDTH = 8;

    // A full table of max counts stays below 2**(cnt_w+sym_w), so the total never wraps.
    function automatic int tot_width(input int cnt_w, input int sym_w);
        return cnt_w + sym_w;
    endfunction

    typedef enum logic [1:0] {
        RDY,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/ans_hs_sink.sv
// Four-phase handshake sink: one accept strobe per request beat, parks in DONE once told to stop.
module ans_hs_sink
    import ans_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_vld,
    input  logic stop,
    output logic in_rdy,
    output logic accept
);

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst || clear) state <= RDY;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            RDY: begin
                // A restart on the same edge drops the beat.
                if (in_vld && !rst && !clear) begin
                    accept     = 1'b1;
                    state_next = stop ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!in_vld) state_next = RDY;
            end
            DONE: state_next = DONE;
            default: state_next = RDY;
        endcase
    end

    assign in_rdy = (state == RDY);

endmodule

// File: rtl/ans_table_loader.sv
// Loads per-symbol frequency counts, builds the cumulative-start table and checks the total.
module ans_table_loader
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH  = DEF_SYM_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int PREC_WIDTH = DEF_PREC_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           clear,
    input  logic [CNT_WIDTH-1:0]                           in,
    input  logic                                           in_last,
    input  logic                                           in_vld,
    output logic                                           in_rdy,
    output logic [CNT_WIDTH-1:0]                           counts [2**SYM_WIDTH],
    output logic [tot_width(CNT_WIDTH, SYM_WIDTH)-1:0]     cum    [2**SYM_WIDTH],
    output logic [SYM_WIDTH:0]                             nsym,
    output logic                                           done,
    output logic                                           ok,
    output logic                                           err
);

    localparam int NSYM      = 2**SYM_WIDTH;
    localparam int TOT_WIDTH = tot_width(CNT_WIDTH, SYM_WIDTH);
    localparam logic [TOT_WIDTH-1:0] TARGET = TOT_WIDTH'(1) << PREC_WIDTH;

    logic                 accept;
    logic                 stop;
    logic [SYM_WIDTH-1:0] idx;
    logic [TOT_WIDTH-1:0] total;
    logic [TOT_WIDTH-1:0] total_next;

    assign total_next = total + TOT_WIDTH'(in);
    assign stop       = in_last || (idx == SYM_WIDTH'(NSYM - 1));

    ans_hs_sink u_sink (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .in_vld (in_vld),
        .stop   (stop),
        .in_rdy (in_rdy),
        .accept (accept)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NSYM; i++) begin
                counts[i] <= '0;
                cum[i]    <= '0;
            end
            total <= '0;
            idx   <= '0;
            nsym  <= '0;
            done  <= 1'b0;
            ok    <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            counts[idx] <= in;
            cum[idx]    <= total;
            total       <= total_next;
            // idx wraps to 0 after the last slot; it is never used again in DONE.
            idx         <= idx + SYM_WIDTH'(1);
            nsym        <= nsym + (SYM_WIDTH + 1)'(1);
            if (stop) begin
                done <= 1'b1;
                ok   <= (total_next == TARGET);
                err  <= (total_next != TARGET);
            end
        end
    end

endmodule

// File: tb/tb_ans_table_loader.sv
// Directed and randomized checks of ans_table_loader against a beat-list reference model.
module tb_ans_table_loader;

    localparam int SW = 2;
    localparam int CW = 8;
    localparam int PW = 4;
    localparam int NS = 1 << SW;
    localparam int TW = CW + SW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] in = '0;
    logic          in_last = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [CW-1:0] counts [NS];
    logic [TW-1:0] cum    [NS];
    logic [SW:0]   nsym;
    logic          done, ok, err;

    int tests = 0;
    int fails = 0;

    // Reference model: the list of accepted counts plus handshake phase.
    int q[$];
    bit m_rdy  = 1'b1;
    bit m_done = 1'b0;

    ans_table_loader #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .PREC_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in(in), .in_last(in_last),
        .in_vld(in_vld), .in_rdy(in_rdy), .counts(counts), .cum(cum),
        .nsym(nsym), .done(done), .ok(ok), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sum;
        sum = 0;
        foreach (q[i]) sum += q[i];
        chk({tag, ".in_rdy"}, 32'(in_rdy), 32'(m_rdy));
        chk({tag, ".nsym"},   32'(nsym),   32'(q.size()));
        chk({tag, ".done"},   32'(done),   32'(m_done));
        chk({tag, ".ok"},     32'(ok),     32'(m_done && sum == (1 << PW)));
        chk({tag, ".err"},    32'(err),    32'(m_done && sum != (1 << PW)));
        for (int i = 0; i < NS; i++) begin
            int c;
            c = 0;
            for (int j = 0; j < i && j < q.size(); j++) c += q[j];
            chk($sformatf("%s.counts%0d", tag, i), 32'(counts[i]), (i < q.size()) ? 32'(q[i]) : 32'd0);
            chk($sformatf("%s.cum%0d", tag, i),    32'(cum[i]),    (i < q.size()) ? 32'(c) : 32'd0);
        end
    endtask

    // Drive one cycle, advance the model by the handshake rules, then check at the falling edge.
    task automatic step(input string tag, input logic v, input int d, input logic l,
                        input logic c, input logic r);
        in_vld = v; in = CW'(d); in_last = l; clear = c; rst = r;
        @(posedge clk);
        if (r || c) begin
            q.delete();
            m_done = 1'b0;
            m_rdy  = 1'b1;
        end else if (m_rdy && v) begin
            q.push_back(d);
            m_rdy = 1'b0;
            if (l || q.size() == NS) m_done = 1'b1;
        end else if (!m_rdy && !m_done && !v) begin
            m_rdy = 1'b1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic beat(input string tag, input int d, input logic l, input int hold);
        repeat (hold) step(tag, 1'b1, d, l, 1'b0, 1'b0);
        step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step("reset", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step("idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Full table, exact total.
        beat("full", 3, 0, 1); beat("full", 5, 0, 1); beat("full", 4, 0, 1); beat("full", 4, 0, 1);
        chk("full.cum3_direct", 32'(cum[3]), 32'd12);
        chk("full.ok_direct", 32'(ok), 32'd1);
        beat("full.post", 9, 0, 2);

        // Reset from DONE.
        do_reset();
        chk("rst.done_direct", 32'(done), 32'd0);

        // Early end, then an ignored pulse.
        beat("early", 10, 0, 1); beat("early", 6, 1, 1);
        chk("early.nsym_direct", 32'(nsym), 32'd2);
        beat("early.post", 1, 1, 1);

        // Bad totals.
        do_reset();
        repeat (4) beat("bad3", 3, 0, 1);
        chk("bad3.err_direct", 32'(err), 32'd1);
        do_reset();
        repeat (4) beat("bad15", 15, 0, 1);
        chk("bad15.cum3_direct", 32'(cum[3]), 32'd45);

        // Request held for six cycles gives one accept.
        do_reset();
        beat("hold", 7, 0, 6);
        chk("hold.nsym_direct", 32'(nsym), 32'd1);

        // Clear wins over a coincident accept, then reload.
        do_reset();
        beat("clr", 2, 0, 1); beat("clr", 2, 0, 1);
        step("clr.hit", 1'b1, 2, 1'b0, 1'b1, 1'b0);
        chk("clr.nsym_direct", 32'(nsym), 32'd0);
        step("clr.idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) beat("reload", 4, 0, 1);
        chk("reload.cum2_direct", 32'(cum[2]), 32'd8);

        // Randomized beats, hold lengths, early ends and occasional clears.
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int b = 0; b < 6; b++) begin
                int d;
                d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) d = int'($urandom_range(0, 8));
                if ($urandom_range(0, 9) == 0)
                    step("rnd.clr", 1'b1, d, 1'b0, 1'b1, 1'b0);
                beat("rnd", d, logic'($urandom_range(0, 4) == 0), int'($urandom_range(1, 3)));
                if ($urandom_range(0, 1) == 0)
                    step("rnd.gap", 1'b0, 0, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
